// File: rtl/counter_test_pkg.sv
// Shared types, next-value model and harness bit map for the
// up/down counter test harness.
package counter_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        FAIL  = 2'd3
    } mon_state_t;

    // Positions of the monitor outputs on the 128-bit OUT harness bus
    localparam int OUT_EXP_LSB       = 40;
    localparam int OUT_MISMATCH_BIT  = 44;
    localparam int OUT_ERR_FLAG_BIT  = 45;
    localparam int OUT_STATE_LSB     = 46;
    localparam int OUT_ERR_CNT_LSB   = 48;
    localparam int OUT_FIRST_OBS_LSB = 56;
    localparam int OUT_FIRST_EXP_LSB = 60;

    // Callers truncate the result to the counter width, which gives
    // the mod 2^WIDTH wrap in both directions.
    function automatic logic [31:0] next_val(
        input logic        ctl_rst,
        input logic        ud,
        input logic [31:0] v
    );
        if (ctl_rst)
            return 32'd0;
        else if (ud)
            return v - 32'd1;
        else
            return v + 32'd1;
    endfunction

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Saturating incrementer with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (clr)
            value <= '0;
        else if (inc && (value != {W{1'b1}}))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/counter_monitor.sv
// Reference-model monitor for the 4-bit up/down test counter:
// predicts each registered count and records divergences.
module counter_monitor
    import counter_test_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int CHK_CNT_W   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 dut_rst,
    input  logic                 up_down,
    input  logic [WIDTH-1:0]     count,
    output logic [WIDTH-1:0]     expected,
    output logic                 mismatch,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [CHK_CNT_W-1:0] chk_count,
    output logic [WIDTH-1:0]     first_err_obs,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [1:0]           state
);

    mon_state_t       state_q;
    mon_state_t       state_d;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] f_cnt;
    logic [WIDTH-1:0] f_exp;
    logic             miss;
    logic             chk_inc;

    assign f_cnt = WIDTH'(next_val(dut_rst, up_down, 32'(count)));
    assign f_exp = WIDTH'(next_val(dut_rst, up_down, 32'(expected)));
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        exp_d   = expected;
        miss    = 1'b0;
        chk_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable)
                    state_d = ACQ;
            end
            ACQ: begin
                exp_d   = f_cnt;
                state_d = enable ? TRACK : IDLE;
            end
            TRACK: begin
                chk_inc = 1'b1;
                state_d = enable ? TRACK : IDLE;
                if (count != expected) begin
                    miss = 1'b1;
                    // Resync on the observed value so one bad sample
                    // costs exactly one mismatch.
                    if (STOP_ON_ERR)
                        state_d = FAIL;
                    else
                        exp_d = f_cnt;
                end else begin
                    exp_d = f_exp;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            expected      <= '0;
            mismatch      <= 1'b0;
            err_flag      <= 1'b0;
            first_err_obs <= '0;
            first_err_exp <= '0;
        end else begin
            state_q  <= state_d;
            expected <= exp_d;
            mismatch <= miss;
            if (miss)
                err_flag <= 1'b1;
            if (miss && !err_flag) begin
                first_err_obs <= count;
                first_err_exp <= expected;
            end
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (miss),
        .value (err_count)
    );

    sat_counter #(.W(CHK_CNT_W)) u_chk_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (chk_inc),
        .value (chk_count)
    );

endmodule
